// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: state encodings, idle instruction word and opcode field layout shared with the control unit
package fetch_seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_t;
  localparam logic [15:0] NOP_WORD = 16'h7C00;
  localparam int OP_W = 6;
endpackage

// File: rtl/fetch_seq_prog_mem.sv
// fetch_seq_prog_mem: program store with synchronous write and zero-latency read
module fetch_seq_prog_mem #(
  parameter int AW = 10,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [IW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [IW-1:0] o_rdata
);
  logic [IW-1:0] r_mem [2**AW];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch, PC sequencing, zero flag and run/halt/load control for the single-cycle CPU
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int AW = 10,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          load_start,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  input  logic          s_inc,
  input  logic          wez,
  input  logic          zalu,
  output logic [IW-1:0] instr,
  output logic [5:0]    opcode,
  output logic          z,
  output logic [AW-1:0] pc,
  output logic [1:0]    state,
  output logic [15:0]   retired
);
  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt, r_laddr, w_laddr_nxt, w_tgt;
  logic          r_z, w_z_nxt, w_we;
  logic [15:0]   r_ret, w_ret_nxt;
  logic [IW-1:0] w_rdata;
  fetch_seq_prog_mem #(.AW(AW), .IW(IW)) prog_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_laddr),
    .i_wdata (load_data),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );
  assign instr      = (r_state == ST_RUN) ? w_rdata : IW'(NOP_WORD);
  assign opcode     = instr[IW-1 -: OP_W];
  assign w_tgt      = instr[AW-1:0];
  assign load_ready = (r_state == ST_LOAD);
  assign z          = r_z;
  assign pc         = r_pc;
  assign state      = r_state;
  assign retired    = r_ret;
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_z_nxt     = r_z;
    w_ret_nxt   = r_ret;
    w_laddr_nxt = r_laddr;
    w_we        = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT:
        if (load_start) begin
          w_state_nxt = ST_LOAD;
          w_laddr_nxt = '0;
        end else if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = '0;
          w_z_nxt     = 1'b0;
          w_ret_nxt   = '0;
        end
      ST_LOAD:
        if (load_valid) begin
          w_we        = 1'b1;
          w_laddr_nxt = r_laddr + 1'b1;
          // the top address ends the burst so the load never wraps onto word 0
          if (load_last || &r_laddr) w_state_nxt = ST_IDLE;
        end
      default: begin
        w_pc_nxt  = s_inc ? r_pc + 1'b1 : w_tgt;
        w_z_nxt   = wez ? zalu : r_z;
        w_ret_nxt = &r_ret ? r_ret : r_ret + 1'b1;
        if (!s_inc && w_tgt == r_pc) w_state_nxt = ST_HALT;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_z     <= 1'b0;
      r_ret   <= '0;
      r_laddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_z     <= w_z_nxt;
      r_ret   <= w_ret_nxt;
      r_laddr <= w_laddr_nxt;
    end
endmodule
